// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// sequencer states and the conditional two's-complement negate helper.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    // Widest value the negate helper handles; callers zero-extend into it.
    localparam int MDU_XW = 128;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    // Negates v when en is set; the low bits of the result are correct for
    // any narrower zero-extended operand.
    function automatic logic [MDU_XW-1:0] mdu_neg(input logic [MDU_XW-1:0] v, input logic en);
        logic [MDU_XW-1:0] r;
        if (en) begin
            r = ~v + {{(MDU_XW-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// divide step per cycle, sign fix-up and HI/LO write in a final FIX cycle.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic         rd_req,
    input  logic         rd_sel,
    input  logic         flush,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         stall,
    output logic         done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_e      state_r, state_n;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]      op_r;
    logic            sgn_a_r, sgn_b_r;
    logic [W-1:0]    rs_raw_r, dvsr_r, hi_r, lo_r;
    logic [2*W-1:0]  acc_r;
    logic            busy_r, done_r;

    logic [MDU_XW-1:0] mag_a_x_s, mag_b_x_s, prod_x_s, quo_x_s, rem_x_s;
    logic [W:0]        sum_s, mul_up_s, cand_s, diff_s;
    logic [2*W-1:0]    mul_n_s, div_n_s;
    logic [W-1:0]      hi_fix_s, lo_fix_s;
    logic              go_s, unused_s;

    assign go_s = start & ~flush;

    // Signed operands are reduced to magnitudes as they are latched.
    assign mag_a_x_s = mdu_neg({{(MDU_XW-W){1'b0}}, rs_val}, op[0] & rs_val[W-1]);
    assign mag_b_x_s = mdu_neg({{(MDU_XW-W){1'b0}}, rt_val}, op[0] & rt_val[W-1]);
    assign prod_x_s  = mdu_neg({{(MDU_XW-2*W){1'b0}}, acc_r}, op_r[0] & (sgn_a_r ^ sgn_b_r));
    assign quo_x_s   = mdu_neg({{(MDU_XW-W){1'b0}}, acc_r[W-1:0]}, op_r[0] & (sgn_a_r ^ sgn_b_r));
    assign rem_x_s   = mdu_neg({{(MDU_XW-W){1'b0}}, acc_r[2*W-1:W]}, op_r[0] & sgn_a_r);
    assign unused_s  = ^{mag_a_x_s[MDU_XW-1:W], mag_b_x_s[MDU_XW-1:W], prod_x_s[MDU_XW-1:2*W],
                         quo_x_s[MDU_XW-1:W], rem_x_s[MDU_XW-1:W]};

    assign hi      = hi_r;
    assign lo      = lo_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_data = rd_sel ? hi_r : lo_r;
    assign stall   = busy_r & (start | rd_req | mthi | mtlo);

    // Next-state selection for the IDLE/CALC/FIX sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    state_n = CALC;
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_n = FIX;
                end else begin
                    state_n = CALC;
                end
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Single iteration of shift-add multiply and restoring divide.
    always_comb begin
        sum_s    = {1'b0, acc_r[2*W-1:W]} + {1'b0, dvsr_r};
        mul_up_s = acc_r[0] ? sum_s : {1'b0, acc_r[2*W-1:W]};
        mul_n_s  = {mul_up_s, acc_r[W-1:1]};
        cand_s   = acc_r[2*W-1:W-1];
        diff_s   = cand_s - {1'b0, dvsr_r};
        if (!diff_s[W]) begin
            div_n_s = {diff_s[W-1:0], acc_r[W-2:0], 1'b1};
        end else begin
            div_n_s = {cand_s[W-1:0], acc_r[W-2:0], 1'b0};
        end
    end

    // Final HI/LO values, including the divide-by-zero override.
    always_comb begin
        hi_fix_s = prod_x_s[2*W-1:W];
        lo_fix_s = prod_x_s[W-1:0];
        if (op_r[1]) begin
            if (dvsr_r == {W{1'b0}}) begin
                hi_fix_s = rs_raw_r;
                lo_fix_s = {W{1'b1}};
            end else begin
                hi_fix_s = rem_x_s[W-1:0];
                lo_fix_s = quo_x_s[W-1:0];
            end
        end else begin
            hi_fix_s = prod_x_s[2*W-1:W];
            lo_fix_s = prod_x_s[W-1:0];
        end
    end

    // Sequencer state, status flags and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != IDLE);
            done_r  <= (state_r == FIX) & ~flush;
            cnt_r   <= (state_r == CALC && state_n == CALC) ? cnt_r + CNT_ONE : {CNT_W{1'b0}};
        end
    end

    // Operand latch, accumulator and HI/LO register updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= 2'b00;
            sgn_a_r  <= 1'b0;
            sgn_b_r  <= 1'b0;
            rs_raw_r <= {W{1'b0}};
            dvsr_r   <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            hi_r     <= {W{1'b0}};
            lo_r     <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        op_r     <= op;
                        sgn_a_r  <= rs_val[W-1];
                        sgn_b_r  <= rt_val[W-1];
                        rs_raw_r <= rs_val;
                        dvsr_r   <= mag_b_x_s[W-1:0];
                        acc_r    <= {{W{1'b0}}, mag_a_x_s[W-1:0]};
                    end else if (!start) begin
                        if (mthi) hi_r <= rs_val;
                        if (mtlo) lo_r <= rs_val;
                    end
                end
                CALC: begin
                    if (!flush) acc_r <= op_r[1] ? div_n_s : mul_n_s;
                end
                FIX: begin
                    if (!flush) begin
                        hi_r <= hi_fix_s;
                        lo_r <= lo_fix_s;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised and directed bench for mdu_seq against a cycle-level
// behavioural model built from plain integer multiply/divide.
module tb_mdu_seq;

    localparam int W = 32;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
    logic        mthi = 1'b0, mtlo = 1'b0, rd_req = 1'b0, rd_sel = 1'b0, flush = 1'b0;
    logic [31:0] rd_data, hi, lo;
    logic        busy, stall, done;

    int checks = 0, passes = 0;

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;

    always #5 clk = ~clk;

    mdu_seq #(.W(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .rd_req(rd_req), .rd_sel(rd_sel), .flush(flush),
        .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        longint la, lb;
        int sa, sb;
        case (o)
            2'b00: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin
                la = $signed(a); lb = $signed(b);
                p = la * lb; rh = p[63:32]; rl = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else begin rl = a / b; rh = a % b; end
            end
            default: begin
                if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = a; rh = 32'd0; end
                else begin sa = a; sb = b; rl = sa / sb; rh = sa % sb; end
            end
        endcase
    endfunction

    // Model update on each edge, then comparison of every output just after it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0; m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_cnt > 0) begin
                    if (flush) m_cnt = 0;
                    else begin
                        m_cnt--;
                        if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
                    end
                end else if (start && !flush) begin
                    m_cnt = W + 1;
                    ref_op(op, rs_val, rt_val, p_hi, p_lo);
                end else if (!start) begin
                    if (mthi) m_hi = rs_val;
                    if (mtlo) m_lo = rs_val;
                end
            end
            #1;
            chk("model hi", hi, m_hi);
            chk("model lo", lo, m_lo);
            chk("model busy", busy, m_cnt != 0);
            chk("model done", done, m_done);
            chk("model stall", stall, (m_cnt != 0) && (start || rd_req || mthi || mtlo));
            chk("model rd_data", rd_data, rd_sel ? m_hi : m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk); start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int nb, nd;
        nb = 0; nd = 0;
        issue(o, a, b);
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        chk({name, " busy cycles"}, nb, 33);
        chk({name, " done pulses"}, nd, 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] th, tl, old_h, old_l;
        int nd;
        bit seen;
        logic prev_stall;

        ref_op(2'b01, 32'hFFFF_FFFD, 32'd7, th, tl);
        chk("ref mult hi", th, 32'hFFFF_FFFF);
        chk("ref mult lo", tl, 32'hFFFF_FFEB);
        ref_op(2'b11, 32'hFFFF_FFF9, 32'd2, th, tl);
        chk("ref div q", tl, 32'hFFFF_FFFD);
        chk("ref div r", th, 32'hFFFF_FFFF);

        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("divu 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div -5/0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // mfhi held while busy
        issue(2'b00, 32'h0001_0000, 32'h0001_0001);
        repeat (4) @(negedge clk);
        rd_req = 1'b1; rd_sel = 1'b1;
        seen = 1'b0; prev_stall = stall;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("rd stall in FIX", prev_stall, 1'b1);
                chk("rd stall in done", stall, 1'b0);
                chk("rd data in done", rd_data, 32'h0000_0001);
            end
            prev_stall = stall;
        end
        chk("rd done seen", seen, 1'b1);
        rd_req = 1'b0; rd_sel = 1'b0;

        @(negedge clk); mthi = 1'b1; rs_val = 32'h0000_1234;
        @(negedge clk); mthi = 1'b0;
        chk("mthi idle", hi, 32'h0000_1234);

        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        old_h = hi;
        mthi = 1'b1; rs_val = 32'h0000_DEAD;
        #1 chk("mthi busy stall", stall, 1'b1);
        @(negedge clk); mthi = 1'b0;
        chk("mthi busy ignored", hi, old_h);
        repeat (40) @(negedge clk);

        old_l = lo;
        start = 1'b1; mtlo = 1'b1; op = 2'b00; rs_val = 32'h0000_5555; rt_val = 32'd3;
        @(negedge clk); start = 1'b0; mtlo = 1'b0;
        chk("start+mtlo lo", lo, old_l);
        chk("start+mtlo busy", busy, 1'b1);
        repeat (40) @(negedge clk);
        chk("start+mtlo result", lo, 32'h0000_FFFF);

        // cancels
        old_h = hi; old_l = lo;
        issue(2'b10, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush calc busy", busy, 1'b0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin if (done) nd++; @(negedge clk); end
        chk("flush calc done", nd, 0);
        chk("flush calc hi", hi, old_h);
        chk("flush calc lo", lo, old_l);

        issue(2'b01, 32'd9, 32'd9);
        repeat (32) @(negedge clk);
        chk("fix cycle busy", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush fix busy", busy, 1'b0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin if (done) nd++; @(negedge clk); end
        chk("flush fix done", nd, 0);
        chk("flush fix hi", hi, old_h);
        chk("flush fix lo", lo, old_l);

        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h0000_0ABC;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        issue(2'b00, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid hi", hi, 32'd0);
        chk("rst mid lo", lo, 32'd0);
        chk("rst mid busy", busy, 1'b0);
        @(negedge clk); rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start  = ($urandom % 8) == 0;
            op     = $urandom;
            rs_val = pick();
            rt_val = pick();
            mthi   = ($urandom % 16) == 0;
            mtlo   = ($urandom % 16) == 0;
            rd_req = ($urandom % 4) == 0;
            rd_sel = $urandom;
            flush  = ($urandom % 50) == 0;
        end
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_req = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
